// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer for one external XNOR LFSR: loads a seed, steps until stop code or
// word budget, and streams every generated word through a credit-gated 2-entry FIFO.
module lfsr_seq_ctrl #(
    parameter int unsigned NUM_BITS = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [NUM_BITS-1:0] i_seed,
    input  logic [NUM_BITS-1:0] i_stop_code,
    input  logic [CNT_W-1:0]    i_max_words,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_status,
    output logic [CNT_W-1:0]    o_word_cnt,
    output logic                o_lfsr_en,
    output logic                o_lfsr_load,
    output logic [NUM_BITS-1:0] o_lfsr_seed,
    output logic [NUM_BITS-1:0] o_lfsr_stop_code,
    input  logic                i_lfsr_vld,
    input  logic [NUM_BITS-1:0] i_lfsr_data,
    input  logic                i_lfsr_done,
    output logic                o_m_valid,
    output logic [NUM_BITS-1:0] o_m_data,
    input  logic                i_m_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_BUDGET = 2'b01;
    localparam logic [1:0] ST_STOP   = 2'b10;
    localparam logic [1:0] ST_ABORT  = 2'b11;

    state_t              state;
    logic [CNT_W-1:0]    max_q;
    logic [CNT_W-1:0]    issued;
    logic                stop_hit;
    logic                en_q;

    logic [NUM_BITS-1:0] mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;

    logic                active;
    logic                aborting;
    logic                push;
    logic                pop;
    logic                stop_seen;
    logic [2:0]          occupancy;
    logic                credit_ok;

    assign active    = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
    assign aborting  = active && i_abort;
    assign push      = active && i_lfsr_vld && !i_abort;
    assign pop       = o_m_valid && i_m_ready;
    assign stop_seen = push && i_lfsr_done;

    // Words already buffered after this cycle's pop, plus the one arriving now.
    assign occupancy = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, en_q};
    assign credit_ok = occupancy < 3'd2;

    assign o_busy    = (state != S_IDLE);
    assign o_m_valid = (fifo_cnt != 2'd0);
    assign o_m_data  = mem[rd_ptr];

    always_comb begin
        o_lfsr_en   = 1'b0;
        o_lfsr_load = 1'b0;
        case (state)
            S_LOAD: begin
                o_lfsr_en   = !i_abort;
                o_lfsr_load = !i_abort;
            end
            S_RUN: begin
                o_lfsr_en = !i_abort && (issued < max_q) && credit_ok
                            && !(i_lfsr_vld && i_lfsr_done);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            o_done           <= 1'b0;
            o_status         <= ST_NONE;
            o_word_cnt       <= '0;
            o_lfsr_seed      <= '0;
            o_lfsr_stop_code <= '0;
            max_q            <= '0;
            issued           <= '0;
            stop_hit         <= 1'b0;
            en_q             <= 1'b0;
            mem[0]           <= '0;
            mem[1]           <= '0;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            fifo_cnt         <= 2'd0;
        end else begin
            en_q   <= o_lfsr_en;
            o_done <= 1'b0;
            if (pop) begin
                o_word_cnt <= o_word_cnt + CNT_W'(1);
            end

            if (aborting) begin
                fifo_cnt <= 2'd0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= i_lfsr_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            end

            if (aborting) begin
                o_status <= ST_ABORT;
                o_done   <= 1'b1;
                state    <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            o_word_cnt <= '0;
                            if (i_max_words == '0) begin
                                o_status <= ST_BUDGET;
                                o_done   <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                o_lfsr_seed      <= i_seed;
                                o_lfsr_stop_code <= i_stop_code;
                                max_q            <= i_max_words;
                                o_status         <= ST_NONE;
                                stop_hit         <= 1'b0;
                                state            <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        issued <= CNT_W'(1);
                        state  <= S_RUN;
                    end
                    S_RUN: begin
                        if (o_lfsr_en) begin
                            issued <= issued + CNT_W'(1);
                        end
                        if (stop_seen) begin
                            stop_hit <= 1'b1;
                        end
                        if ((issued == max_q) || stop_seen) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        // A final in-flight word may still match the stop code.
                        if (stop_seen) begin
                            stop_hit <= 1'b1;
                        end else if (!en_q && (fifo_cnt == 2'd0)) begin
                            o_status <= stop_hit ? ST_STOP : ST_BUDGET;
                            o_done   <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    fifo_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && !pop && (fifo_cnt == 2'd2)));

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: behavioural LFSR model on the LFSR side and a
// scoreboard of expected stream words checked on every accepted handshake.
module tb_lfsr_seq_ctrl;

    localparam int unsigned NB = 64;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [NB-1:0] i_seed;
    logic [NB-1:0] i_stop_code;
    logic [CW-1:0] i_max_words;
    logic          i_abort;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_status;
    logic [CW-1:0] o_word_cnt;
    logic          o_lfsr_en;
    logic          o_lfsr_load;
    logic [NB-1:0] o_lfsr_seed;
    logic [NB-1:0] o_lfsr_stop_code;
    logic          lvld;
    logic [NB-1:0] lq;
    logic          lfsr_done;
    logic          o_m_valid;
    logic [NB-1:0] o_m_data;
    logic          i_m_ready;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(.NUM_BITS(NB), .CNT_W(CW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (i_start),
        .i_seed          (i_seed),
        .i_stop_code     (i_stop_code),
        .i_max_words     (i_max_words),
        .i_abort         (i_abort),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_status        (o_status),
        .o_word_cnt      (o_word_cnt),
        .o_lfsr_en       (o_lfsr_en),
        .o_lfsr_load     (o_lfsr_load),
        .o_lfsr_seed     (o_lfsr_seed),
        .o_lfsr_stop_code(o_lfsr_stop_code),
        .i_lfsr_vld      (lvld),
        .i_lfsr_data     (lq),
        .i_lfsr_done     (lfsr_done),
        .o_m_valid       (o_m_valid),
        .o_m_data        (o_m_data),
        .i_m_ready       (i_m_ready)
    );

    // XNOR taps at bits 49 and 40 (1-indexed), new bit enters at the LSB.
    function automatic logic [NB-1:0] lfsr_next(input logic [NB-1:0] w);
        return {w[NB-2:0], ~(w[48] ^ w[39])};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lq   <= '0;
            lvld <= 1'b0;
        end else begin
            lvld <= o_lfsr_en;
            if (o_lfsr_en) lq <= o_lfsr_load ? o_lfsr_seed : lfsr_next(lq);
        end
    end
    assign lfsr_done = (lq == o_lfsr_stop_code);

    int            vectors = 0;
    int            miscompares = 0;
    logic [NB-1:0] sb[$];
    int            run_en, run_load, run_pop, max_out;
    int unsigned   pop_cyc_q[$];

    task automatic clear_stats();
        run_en = 0; run_load = 0; run_pop = 0; max_out = 0;
        pop_cyc_q.delete();
    endtask

    task automatic monitor();
        logic          stalled;
        logic [NB-1:0] held;
        logic [NB-1:0] exp;
        int unsigned   cyc;
        stalled = 1'b0; held = '0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                vectors++;
                if (o_m_valid !== 1'b1 || o_m_data !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h",
                             o_m_valid, o_m_data, held);
                end
            end
            if (run_en - run_pop > max_out) max_out = run_en - run_pop;
            if (o_lfsr_en === 1'b1) run_en++;
            if (o_lfsr_load === 1'b1) run_load++;
            if (o_m_valid === 1'b1 && i_m_ready === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got %h, expected no word", o_m_data);
                end else begin
                    exp = sb.pop_front();
                    if (o_m_data !== exp) begin
                        miscompares++;
                        $display("FAIL stream_word: got %h expected %h", o_m_data, exp);
                    end
                end
                run_pop++;
                pop_cyc_q.push_back(cyc);
            end
            stalled = (o_m_valid === 1'b1) && (i_m_ready === 1'b0);
            held    = o_m_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [NB-1:0] seed, input logic [NB-1:0] stop,
                             input logic [CW-1:0] maxw);
        tick();
        i_seed = seed; i_stop_code = stop; i_max_words = maxw; i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, input int unsigned limit);
        seen = 1'b0;
        for (int unsigned k = 0; k < limit; k++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_seed = '0; i_stop_code = '0;
        i_max_words = '0; i_abort = 1'b0; i_m_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({o_busy, o_done, o_status, o_word_cnt, o_lfsr_en, o_lfsr_load, o_m_valid} !== '0 ||
            o_lfsr_seed !== '0 || o_lfsr_stop_code !== '0 || o_m_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b status=%b cnt=%0d en=%b valid=%b, expected all 0",
                     o_busy, o_done, o_status, o_word_cnt, o_lfsr_en, o_m_valid);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_budget();
        bit seen;
        int span;
        clear_stats();
        i_m_ready = 1'b1;
        sb.push_back(64'h1); sb.push_back(64'h3); sb.push_back(64'h7);
        sb.push_back(64'hF); sb.push_back(64'h1F);
        start_run(64'h1, '1, 5);
        wait_done(seen, 200);
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL budget_done: got no o_done, expected pulse"); end
        tick();
        span = (pop_cyc_q.size() == 5) ? int'(pop_cyc_q[4] - pop_cyc_q[0]) : -1;
        vectors++;
        if (o_status !== 2'b01) begin miscompares++; $display("FAIL budget_status: got %b expected 01", o_status); end
        vectors++;
        if (o_word_cnt !== 5) begin miscompares++; $display("FAIL budget_cnt: got %0d expected 5", o_word_cnt); end
        vectors++;
        if (run_load != 1 || run_en != 5) begin
            miscompares++; $display("FAIL budget_en: got load=%0d en=%0d expected load=1 en=5", run_load, run_en);
        end
        vectors++;
        if (span != 4) begin miscompares++; $display("FAIL budget_throughput: got span %0d expected 4", span); end
        vectors++;
        if (sb.size() != 0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL budget_end: got pending=%0d busy=%b done=%b expected 0 0 0", sb.size(), o_busy, o_done);
        end
    endtask

    task automatic test_stop();
        bit seen;
        clear_stats();
        sb.push_back(64'h1); sb.push_back(64'h3); sb.push_back(64'h7);
        start_run(64'h1, 64'h7, 100);
        wait_done(seen, 300);
        tick();
        vectors++;
        if (!seen || o_status !== 2'b10) begin
            miscompares++; $display("FAIL stop_status: got done=%b status=%b expected 1 10", seen, o_status);
        end
        vectors++;
        if (o_word_cnt !== 3 || sb.size() != 0) begin
            miscompares++; $display("FAIL stop_cnt: got %0d pending=%0d expected 3 0", o_word_cnt, sb.size());
        end
        vectors++;
        if (run_en > 3) begin miscompares++; $display("FAIL stop_en_cycles: got %0d expected <=3", run_en); end
    endtask

    task automatic test_backpressure();
        logic [NB-1:0] w;
        bit seen;
        clear_stats();
        w = 64'h1;
        for (int i = 0; i < 50; i++) begin
            sb.push_back(w);
            w = lfsr_next(w);
        end
        i_m_ready = 1'b1;
        start_run(64'h1, '1, 50);
        seen = 1'b0;
        for (int unsigned c = 0; c < 3000; c++) begin
            i_m_ready = (c < 6) ? 1'b1 : (c < 16) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (o_done === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        i_m_ready = 1'b1;
        tick();
        vectors++;
        if (!seen || o_status !== 2'b01) begin
            miscompares++; $display("FAIL bp_status: got done=%b status=%b expected 1 01", seen, o_status);
        end
        vectors++;
        if (o_word_cnt !== 50 || sb.size() != 0) begin
            miscompares++; $display("FAIL bp_cnt: got %0d pending=%0d expected 50 0", o_word_cnt, sb.size());
        end
        vectors++;
        if (max_out > 2) begin miscompares++; $display("FAIL bp_occupancy: got %0d expected <=2", max_out); end
    endtask

    task automatic test_abort();
        logic [NB-1:0] w;
        bit seen;
        int pops;
        clear_stats();
        w = 64'h1;
        for (int i = 0; i < 20; i++) begin
            sb.push_back(w);
            w = lfsr_next(w);
        end
        i_m_ready = 1'b1;
        start_run(64'h1, '1, 20);
        pops = 0;
        for (int unsigned c = 0; c < 100 && pops < 3; c++) begin
            @(negedge clk);
            if (o_m_valid === 1'b1 && i_m_ready === 1'b1) pops++;
        end
        tick();
        i_abort = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_lfsr_en !== 1'b0 || o_m_valid !== 1'b1) begin
            miscompares++; $display("FAIL abort_same_cycle: got en=%b valid=%b expected en=0 valid=1", o_lfsr_en, o_m_valid);
        end
        tick();
        i_abort = 1'b0;
        sb.delete();
        @(negedge clk);
        vectors++;
        if (o_m_valid !== 1'b0 || o_done !== 1'b1 || o_status !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_next: got valid=%b done=%b status=%b expected 0 1 11", o_m_valid, o_done, o_status);
        end
        vectors++;
        if (o_word_cnt !== 4) begin miscompares++; $display("FAIL abort_cnt: got %0d expected 4", o_word_cnt); end
        repeat (5) tick();
        vectors++;
        if (o_busy !== 1'b0 || o_status !== 2'b11) begin
            miscompares++; $display("FAIL abort_hold: got busy=%b status=%b expected 0 11", o_busy, o_status);
        end
        sb.push_back(64'h1); sb.push_back(64'h3); sb.push_back(64'h7);
        start_run(64'h1, '1, 3);
        wait_done(seen, 200);
        tick();
        vectors++;
        if (!seen || o_status !== 2'b01 || o_word_cnt !== 3 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL abort_restart: got done=%b status=%b cnt=%0d pending=%0d expected 1 01 3 0",
                     seen, o_status, o_word_cnt, sb.size());
        end
    endtask

    task automatic test_corner_cases();
        bit seen;
        clear_stats();
        start_run(64'h1, '1, 0);
        wait_done(seen, 50);
        tick();
        vectors++;
        if (!seen || o_status !== 2'b01 || o_word_cnt !== 0 || run_en != 0) begin
            miscompares++;
            $display("FAIL zero_budget: got done=%b status=%b cnt=%0d en=%0d expected 1 01 0 0",
                     seen, o_status, o_word_cnt, run_en);
        end
        clear_stats();
        sb.push_back(64'h5);
        start_run(64'h5, 64'h5, 10);
        wait_done(seen, 100);
        tick();
        vectors++;
        if (!seen || o_status !== 2'b10 || o_word_cnt !== 1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL seed_is_stop: got done=%b status=%b cnt=%0d pending=%0d expected 1 10 1 0",
                     seen, o_status, o_word_cnt, sb.size());
        end
        clear_stats();
        sb.push_back(64'h1); sb.push_back(64'h3); sb.push_back(64'h7);
        sb.push_back(64'hF); sb.push_back(64'h1F);
        start_run(64'h1, '1, 5);
        tick();
        i_seed = 64'h100; i_max_words = 2; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(seen, 200);
        tick();
        vectors++;
        if (!seen || o_status !== 2'b01 || o_word_cnt !== 5 || o_lfsr_seed !== 64'h1) begin
            miscompares++;
            $display("FAIL busy_start: got done=%b status=%b cnt=%0d seed=%h expected 1 01 5 1",
                     seen, o_status, o_word_cnt, o_lfsr_seed);
        end
        repeat (4) tick();
        vectors++;
        if (o_busy !== 1'b0 || sb.size() != 0) begin
            miscompares++; $display("FAIL busy_after: got busy=%b pending=%0d expected 0 0", o_busy, sb.size());
        end
    endtask

    task automatic test_midrun_reset();
        clear_stats();
        i_m_ready = 1'b0;
        start_run(64'h1, '1, 50);
        repeat (6) tick();
        vectors++;
        if (o_m_valid !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++; $display("FAIL pre_reset: got valid=%b busy=%b expected 1 1", o_m_valid, o_busy);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_busy, o_done, o_status, o_word_cnt, o_lfsr_en, o_lfsr_load, o_m_valid} !== '0 ||
            o_lfsr_seed !== '0 || o_lfsr_stop_code !== '0 || o_m_data !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: got busy=%b valid=%b en=%b seed=%h data=%h expected all 0",
                     o_busy, o_m_valid, o_lfsr_en, o_lfsr_seed, o_m_data);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        i_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (o_m_valid !== 1'b0 || o_busy !== 1'b0) begin
                miscompares++; $display("FAIL post_reset_idle: got valid=%b busy=%b expected 0 0", o_m_valid, o_busy);
            end
        end
        test_budget();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        rst_n = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_budget();
        test_stop();
        test_backpressure();
        test_abort();
        test_corner_cases();
        test_midrun_reset();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
